// File: rtl/fetch_unit.sv
// IF stage: owns the PC, issues in-order imem fetches and queues returned words
// with their PC until IF/ID accepts them; redirects drop everything still in flight.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int KW = 8;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [31:0]     instr_mem [DEPTH];
  logic [AW-1:0]   head_q;
  logic [AW-1:0]   tail_q;
  logic [AW-1:0]   fill_q;
  logic [CW-1:0]   alloc_cnt;
  logic [CW-1:0]   unfill_cnt;
  logic [KW-1:0]   kill_cnt;
  logic            live_q;

  logic active;
  logic has_data;
  logic accept;
  logic pop;
  logic fill;
  logic kill;

  // Handshakes: a request transfers on a cycle with imem_req_valid && imem_req_ready;
  // an instruction transfers to IF/ID on a cycle with if_valid && id_ready. Neither
  // valid depends on its own ready.
  assign active   = rst && live_q;
  // Entries are allocated and filled in order, so the filled ones are always the
  // oldest: the head is filled whenever some allocated entry is not waiting.
  assign has_data = (alloc_cnt != unfill_cnt);

  assign imem_req_valid = active && !redirect_valid && (alloc_cnt < FULL);
  assign imem_req_addr  = pc_q;
  assign if_valid       = active && has_data && !redirect_valid;
  assign if_pc          = active ? pc_mem[head_q] : '0;
  assign if_instr       = active ? instr_mem[head_q] : '0;

  assign accept = imem_req_valid && imem_req_ready;
  assign pop    = if_valid && id_ready;
  assign kill   = imem_rsp_valid && (kill_cnt != '0);
  assign fill   = imem_rsp_valid && (kill_cnt == '0) && !redirect_valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      live_q     <= 1'b0;
      pc_q       <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      fill_q     <= '0;
      alloc_cnt  <= '0;
      unfill_cnt <= '0;
      kill_cnt   <= '0;
    end else begin
      live_q <= 1'b1;
      if (redirect_valid) begin
        pc_q       <= redirect_pc & ~XLEN'(3);
        head_q     <= '0;
        tail_q     <= '0;
        fill_q     <= '0;
        alloc_cnt  <= '0;
        unfill_cnt <= '0;
        // Every word still owed by memory is now stale; one arriving this cycle
        // is dropped here and so is not counted again.
        kill_cnt   <= kill_cnt + KW'(unfill_cnt) - KW'(imem_rsp_valid);
      end else begin
        if (accept) begin
          pc_q   <= pc_q + XLEN'(4);
          tail_q <= tail_q + AW'(1);
        end
        if (pop)  head_q   <= head_q + AW'(1);
        if (fill) fill_q   <= fill_q + AW'(1);
        if (kill) kill_cnt <= kill_cnt - KW'(1);
        alloc_cnt  <= alloc_cnt + CW'(accept) - CW'(pop);
        unfill_cnt <= unfill_cnt + CW'(accept) - CW'(fill);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) pc_mem[tail_q]    <= pc_q;
    if (fill)   instr_mem[fill_q] <= imem_rsp_data;
  end

  // A live response must either be stale or belong to an outstanding request.
  a_rsp_has_slot : assert property (@(posedge clk) disable iff (!rst)
    (imem_rsp_valid && kill_cnt == '0) |-> (unfill_cnt != '0));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order imem model with fixed or random latency, directed
// fetch streams, and a scoreboard of expected {pc, instr} pairs popped by a monitor.
module tb_fetch_unit;
  localparam int XLEN  = 32;
  // Four entries let a 1-cycle memory sustain one fetch per cycle, since a slot is
  // held from the accept edge until the pop edge.
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            id_ready;
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [31:0]     if_instr;

  fetch_unit #(.XLEN(XLEN), .RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  int cyc = 0;
  int n_acc = 0;
  int n_pop = 0;
  int lat_fix = 1;
  bit lat_rand = 1'b0;
  int first_acc_cyc = -1;
  int first_vld_cyc = -1;
  int last_pop_cyc = -1;
  logic [31:0] pend_addr[$];
  int pend_due[$];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0F13;
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string name);
    check(name, {imem_req_valid, if_valid, if_pc, if_instr}, '0);
  endtask

  // Instruction memory: responses in request order, each no earlier than its latency
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      imem_rsp_valid = 1'b0;
      if (!rst) begin
        pend_addr.delete();
        pend_due.delete();
      end else if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = instr_of(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
      #1;
      if (rst && imem_req_valid && imem_req_ready) begin
        pend_addr.push_back(imem_req_addr);
        pend_due.push_back(cyc + (lat_rand ? int'($urandom_range(1, 4)) : lat_fix));
        if (first_acc_cyc < 0) first_acc_cyc = cyc;
        n_acc++;
      end
    end
  end

  // Scoreboard monitor: every IF/ID transfer must match the oldest expected pair
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (if_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (if_valid && id_ready) begin
        n_pop++;
        last_pop_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop: got pc %0h instr %0h, expected no transfer", if_pc, if_instr);
        end else begin
          check("fetch_pair", {if_pc, if_instr}, exp_q.pop_front());
        end
      end
    end
  end

  // Driver: allow exactly n accepts from pc0, expect n pops, optional stall window
  task automatic run_stream(input int n, input logic [31:0] pc0, input int stall_after,
                            input int stall_len, input bit rand_id);
    int acc0;
    int pop0;
    int budget;
    bit stalled;
    acc0 = n_acc;
    pop0 = n_pop;
    budget = 0;
    stalled = 1'b0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({pc0 + 32'(4 * i), instr_of(pc0 + 32'(4 * i))});
    end
    while (exp_q.size() > 0 && budget < 400) begin
      @(negedge clk);
      budget++;
      imem_req_ready = (n_acc - acc0) < n;
      id_ready = rand_id ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (!stalled && stall_len > 0 && (n_pop - pop0) == stall_after) begin
        stalled = 1'b1;
        id_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          if (s > 0) begin
            @(negedge clk);
            imem_req_ready = (n_acc - acc0) < n;
          end
          #4;
          check("stall_hold", {if_valid, if_pc, if_instr}, {1'b1, exp_q[0]});
        end
        check("stall_issue_stops", {imem_req_valid, 32'((n_acc - acc0) - (n_pop - pop0))},
              {1'b0, 32'(DEPTH)});
      end
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL stream_timeout: %0d entries never delivered, expected 0", exp_q.size());
      exp_q.delete();
    end
    imem_req_ready = 1'b0;
  endtask

  // Stimulus
  initial begin
    int acc0;
    int post_cyc;
    rst            = 1'b0;
    imem_req_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b0;

    // Reset and the cycle after release keep all outputs at zero
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #4;
      check_zero("reset_outputs");
    end
    @(negedge clk);
    rst = 1'b1;
    imem_req_ready = 1'b1;
    #4;
    post_cyc = cyc;
    check_zero("post_reset_outputs");

    // 1: streaming from RESET_PC with 1-cycle memory
    run_stream(8, 32'h0, -1, 0, 1'b0);
    check("first_accept_cycle", 96'(first_acc_cyc), 96'(post_cyc + 1));
    check("req_to_if_valid", 96'(first_vld_cyc - first_acc_cyc), 96'(2));
    check("one_per_cycle", 96'(last_pop_cyc - first_vld_cyc), 96'(7));

    // 2: IF/ID stall mid-stream
    run_stream(12, 32'h20, 4, 5, 1'b0);

    // 3: redirects with slow memory and requests in flight, back to back
    lat_fix = 4;
    acc0 = n_acc;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if ((n_acc - acc0) >= 2) break;
      imem_req_ready = 1'b1;
    end
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    #4;
    check("redirect_blocks", {if_valid, imem_req_valid}, '0);
    @(negedge clk);
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    #4;
    check("redirect_target_addr", {imem_req_valid, imem_req_addr}, {1'b1, 32'h200});
    @(negedge clk);
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    @(negedge clk);
    redirect_valid = 1'b0;
    run_stream(4, 32'h100, -1, 0, 1'b0);

    // 4: redirect to a misaligned target in the same cycle as a response
    lat_fix = 1;
    @(negedge clk);
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    #4;
    check("redirect_with_rsp", {if_valid, imem_req_valid}, '0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #4;
    check("aligned_restart", {imem_req_valid, imem_req_addr}, {1'b1, 32'h100});
    run_stream(3, 32'h100, -1, 0, 1'b0);

    // 5: memory back-pressure, then random latency and random IF/ID stalls
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      imem_req_ready = 1'b0;
      id_ready = 1'b1;
      #4;
      check("req_held_no_ready", {imem_req_valid, imem_req_addr}, {1'b1, 32'h10C});
    end
    lat_rand = 1'b1;
    run_stream(10, 32'h10C, -1, 0, 1'b1);
    lat_rand = 1'b0;

    // 6: PC wrap, then reset with the FIFO full
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    @(negedge clk);
    redirect_valid = 1'b0;
    run_stream(4, 32'hFFFF_FFF8, -1, 0, 1'b0);
    acc0 = n_acc;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      id_ready = 1'b0;
      imem_req_ready = (n_acc - acc0) < DEPTH;
    end
    #4;
    check("full_head", {if_valid, imem_req_valid, if_pc, if_instr},
          {1'b1, 1'b0, 32'h8, instr_of(32'h8)});
    @(negedge clk);
    rst = 1'b0;
    imem_req_ready = 1'b1;
    #4;
    check_zero("mid_reset_outputs");
    @(negedge clk);
    #4;
    check_zero("mid_reset_outputs");
    @(negedge clk);
    rst = 1'b1;
    #4;
    check_zero("post_mid_reset_outputs");
    run_stream(3, 32'h0, -1, 0, 1'b0);

    // Quiet tail: nothing further may reach IF/ID
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      id_ready = 1'b1;
      imem_req_ready = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
